// File: rtl/nonce_tx_scheduler.sv
// nonce_tx_scheduler: lets NUM_HASHERS hasher cores share one byte transmitter.
// Each core has a one-entry holding slot. A round-robin arbiter picks a pending
// slot and sends it as a 5-byte frame: {HDR_TAG, id}, then the nonce LSB first.
// Each byte is paced on the transmitter's busy flag.
module nonce_tx_scheduler #(
  parameter int         NUM_HASHERS = 4,
  parameter logic [3:0] HDR_TAG     = 4'hA
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_HASHERS-1:0]   nonce_valid,
  input  logic [32*NUM_HASHERS-1:0] nonce_in,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic [NUM_HASHERS-1:0]   pending,
  output logic                     overflow,
  output logic [15:0]              frame_count,
  output logic                     idle
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t                  stateReg, stateNext;
  logic [39:0]             shiftReg, shiftNext;
  logic [2:0]              byteCntReg, byteCntNext;
  logic [1:0]              toCntReg, toCntNext;
  logic                    txStartReg, txStartNext;
  logic [7:0]              txDataReg, txDataNext;
  logic [15:0]             frameCountReg, frameCountNext;
  logic [3:0]              rrPtrReg, rrPtrNext;

  logic [31:0]             slotReg [NUM_HASHERS];
  logic [NUM_HASHERS-1:0]  pendingReg;
  logic                    overflowReg;

  logic                    grantValid;
  logic [3:0]              grantId;
  logic [NUM_HASHERS-1:0]  grantVec;
  logic [31:0]             grantNonce;
  logic [15:0]             pendWide;
  int                      scanIdx;

  // Round-robin search: first pending slot after the last granted id, wrapping.
  // A grant is only allowed while the transmitter is quiet, which also covers
  // a transmitter still finishing a byte from before a reset.
  always_comb begin
    grantValid = 1'b0;
    grantId    = '0;
    scanIdx    = 0;
    pendWide   = '0;
    pendWide[NUM_HASHERS-1:0] = pendingReg;
    if (stateReg == IDLE && !tx_busy) begin
      for (int k = 1; k <= NUM_HASHERS; k++) begin
        scanIdx = int'(rrPtrReg) + k;
        if (scanIdx >= NUM_HASHERS) scanIdx = scanIdx - NUM_HASHERS;
        if (!grantValid && pendWide[4'(scanIdx)]) begin
          grantValid = 1'b1;
          grantId    = 4'(scanIdx);
        end
      end
    end
  end

  // Decode the grant into a one-hot vector and select the granted slot's nonce.
  always_comb begin
    grantNonce = '0;
    grantVec   = '0;
    for (int i = 0; i < NUM_HASHERS; i++) begin
      if (grantValid && grantId == 4'(i)) begin
        grantNonce  = slotReg[i];
        grantVec[i] = 1'b1;
      end
    end
  end

  // Holding slots: a capture always wins over a grant-clear on the same slot, so a
  // nonce arriving on the grant edge stays queued while the old one is framed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pendingReg  <= '0;
      overflowReg <= 1'b0;
      for (int i = 0; i < NUM_HASHERS; i++) slotReg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_HASHERS; i++) begin
        if (nonce_valid[i]) begin
          slotReg[i]    <= nonce_in[32*i +: 32];
          pendingReg[i] <= 1'b1;
          if (pendingReg[i] && !grantVec[i]) overflowReg <= 1'b1;
        end else if (grantVec[i]) begin
          pendingReg[i] <= 1'b0;
        end
      end
    end
  end

  // Frame sequencer: next state and next values of every registered output.
  always_comb begin
    stateNext      = stateReg;
    shiftNext      = shiftReg;
    byteCntNext    = byteCntReg;
    toCntNext      = toCntReg;
    txStartNext    = 1'b0;
    txDataNext     = txDataReg;
    frameCountNext = frameCountReg;
    rrPtrNext      = rrPtrReg;
    case (stateReg)
      IDLE: begin
        if (grantValid) begin
          stateNext   = SEND;
          shiftNext   = {grantNonce, HDR_TAG, grantId};
          byteCntNext = '0;
          rrPtrNext   = grantId;
        end
      end
      SEND: begin
        txStartNext = 1'b1;
        txDataNext  = shiftReg[7:0];
        toCntNext   = '0;
        stateNext   = WAIT_HI;
      end
      WAIT_HI: begin
        // A transmitter that never acknowledges must not stall the frame.
        if (tx_busy || toCntReg == 2'd3) stateNext = WAIT_LO;
        else                             toCntNext = toCntReg + 2'd1;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (byteCntReg == 3'd4) begin
            frameCountNext = frameCountReg + 16'd1;
            stateNext      = IDLE;
          end else begin
            shiftNext   = shiftReg >> 8;
            byteCntNext = byteCntReg + 3'd1;
            stateNext   = SEND;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Sequencer state and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg      <= IDLE;
      shiftReg      <= '0;
      byteCntReg    <= '0;
      toCntReg      <= '0;
      txStartReg    <= 1'b0;
      txDataReg     <= '0;
      frameCountReg <= '0;
      rrPtrReg      <= 4'(NUM_HASHERS - 1);
    end else begin
      stateReg      <= stateNext;
      shiftReg      <= shiftNext;
      byteCntReg    <= byteCntNext;
      toCntReg      <= toCntNext;
      txStartReg    <= txStartNext;
      txDataReg     <= txDataNext;
      frameCountReg <= frameCountNext;
      rrPtrReg      <= rrPtrNext;
    end
  end

  assign tx_start    = txStartReg;
  assign tx_data     = txDataReg;
  assign pending     = pendingReg;
  assign overflow    = overflowReg;
  assign frame_count = frameCountReg;
  assign idle        = (stateReg == IDLE);

endmodule

// File: tb/tb_nonce_tx_scheduler.sv
// Testbench for nonce_tx_scheduler: directed stimulus, with expected bytes queued
// in a scoreboard that a negedge monitor checks against every start pulse.
module tb_nonce_tx_scheduler;
  localparam int N        = 4;
  localparam int BUSY_LEN = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     nonceValid = '0;
  logic [32*N-1:0]  nonceIn = '0;
  logic             txBusy;
  logic             txStart;
  logic [7:0]       txData;
  logic [N-1:0]     pending;
  logic             overflow;
  logic [15:0]      frameCount;
  logic             idle;

  int               busyCnt = 0;
  bit               txDead = 1'b0;
  int               cycle = 0;
  logic [7:0]       sbQ[$];
  int               pulseCycles[$];
  int               checkCount = 0;
  int               passCount = 0;

  always #5 clk = ~clk;

  nonce_tx_scheduler #(.NUM_HASHERS(N), .HDR_TAG(4'hA)) dut (
    .clk(clk), .reset(reset), .nonce_valid(nonceValid), .nonce_in(nonceIn),
    .tx_busy(txBusy), .tx_start(txStart), .tx_data(txData), .pending(pending),
    .overflow(overflow), .frame_count(frameCount), .idle(idle)
  );

  // Transmitter model: busy rises one cycle after a start, lasts BUSY_LEN cycles,
  // and ignores the scheduler's reset. In dead mode it never goes busy.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (txStart && !txDead) busyCnt <= BUSY_LEN;
    else if (busyCnt > 0)   busyCnt <= busyCnt - 1;
  end
  assign txBusy = (busyCnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: each start pulse must meet an idle transmitter and carry the next expected byte.
  always @(negedge clk) begin
    if (txStart) begin
      pulseCycles.push_back(cycle);
      check("start_while_busy", {31'd0, txBusy}, 32'd0);
      if (sbQ.size() == 0) begin
        checkCount++;
        $display("FAIL tx_data: got %0h, expected no byte", txData);
      end else begin
        check("tx_data", {24'd0, txData}, {24'd0, sbQ.pop_front()});
      end
    end
  end

  task automatic pushFrame(input logic [3:0] id, input logic [31:0] n);
    sbQ.push_back({4'hA, id});
    sbQ.push_back(n[7:0]);
    sbQ.push_back(n[15:8]);
    sbQ.push_back(n[23:16]);
    sbQ.push_back(n[31:24]);
  endtask

  task automatic sendNonce(input int id, input logic [31:0] n);
    @(negedge clk);
    nonceValid[id]      = 1'b1;
    nonceIn[32*id +: 32] = n;
    @(negedge clk);
    nonceValid = '0;
  endtask

  task automatic waitDone(input string name, input int maxCycles);
    int n = 0;
    while (!(sbQ.size() == 0 && idle && pending == '0) && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxCycles) begin
      checkCount++;
      $display("FAIL %s: timeout after %0d cycles, got %0d bytes outstanding, expected 0",
               name, n, sbQ.size());
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    nonceValid = '0;
    check("leftover_bytes", sbQ.size(), 32'd0);
    sbQ.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (BUSY_LEN + 2) @(negedge clk);
  endtask

  initial begin
    int n;
    // Reset values
    @(negedge clk);
    check("rst_tx_start", {31'd0, txStart}, 32'd0);
    check("rst_tx_data", {24'd0, txData}, 32'd0);
    check("rst_pending", {28'd0, pending}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_frame_count", {16'd0, frameCount}, 32'd0);
    check("rst_idle", {31'd0, idle}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single frame and start latency
    pushFrame(4'd0, 32'h12345678);
    sendNonce(0, 32'h12345678);
    check("t1_pending", {28'd0, pending}, 32'h1);
    check("t1_start_t0", {31'd0, txStart}, 32'd0);
    @(negedge clk);
    check("t1_start_t1", {31'd0, txStart}, 32'd0);
    check("t1_idle_t1", {31'd0, idle}, 32'd0);
    @(negedge clk);
    check("t1_start_t2", {31'd0, txStart}, 32'd1);
    waitDone("t1_done", 200);
    check("t1_frame_count", {16'd0, frameCount}, 32'd1);
    check("t1_pending_end", {28'd0, pending}, 32'd0);

    // 2: simultaneous requests served in round-robin order from reset
    doReset();
    for (int i = 0; i < N; i++) pushFrame(4'(i), 32'(i));
    @(negedge clk);
    nonceValid = 4'hF;
    nonceIn = {32'h3, 32'h2, 32'h1, 32'h0};
    @(negedge clk);
    nonceValid = '0;
    check("t2_pending_all", {28'd0, pending}, 32'hF);
    waitDone("t2_done", 600);
    check("t2_frame_count", {16'd0, frameCount}, 32'd4);
    check("t2_overflow", {31'd0, overflow}, 32'd0);

    // 3: overwrite of an unsent slot while another frame is in flight
    doReset();
    pushFrame(4'd0, 32'h000000F0);
    sendNonce(0, 32'h000000F0);
    repeat (3) @(negedge clk);
    pushFrame(4'd2, 32'hAAAA0002);
    sendNonce(2, 32'hAAAA0001);
    sendNonce(2, 32'hAAAA0002);
    check("t3_overflow_set", {31'd0, overflow}, 32'd1);
    check("t3_pending", {28'd0, pending}, 32'h4);
    waitDone("t3_done", 300);
    check("t3_overflow_sticky", {31'd0, overflow}, 32'd1);
    check("t3_frame_count", {16'd0, frameCount}, 32'd2);

    // 4: capture on the grant edge of the same slot
    doReset();
    check("t4_overflow_cleared", {31'd0, overflow}, 32'd0);
    pushFrame(4'd1, 32'h11110000);
    pushFrame(4'd1, 32'h22220000);
    @(negedge clk);
    nonceValid[1] = 1'b1;
    nonceIn[63:32] = 32'h11110000;
    @(negedge clk);
    nonceIn[63:32] = 32'h22220000;
    @(negedge clk);
    nonceValid = '0;
    check("t4_pending_kept", {28'd0, pending}, 32'h2);
    check("t4_overflow", {31'd0, overflow}, 32'd0);
    waitDone("t4_done", 300);
    check("t4_frame_count", {16'd0, frameCount}, 32'd2);
    check("t4_overflow_end", {31'd0, overflow}, 32'd0);

    // 5: reset mid-frame with the transmitter still busy
    pulseCycles.delete();
    pushFrame(4'd3, 32'hDEADBEEF);
    sendNonce(3, 32'hDEADBEEF);
    sendNonce(2, 32'h00000001);
    sendNonce(2, 32'h00000002);
    n = 0;
    while (pulseCycles.size() < 2 && n < 100) begin @(negedge clk); n++; end
    while (!txBusy && n < 100) begin @(negedge clk); n++; end
    check("t5_reached_busy", {31'd0, txBusy}, 32'd1);
    check("t5_overflow_pre", {31'd0, overflow}, 32'd1);
    reset = 1'b1;
    #1;
    check("t5_tx_start", {31'd0, txStart}, 32'd0);
    check("t5_tx_data", {24'd0, txData}, 32'd0);
    check("t5_pending", {28'd0, pending}, 32'd0);
    check("t5_overflow", {31'd0, overflow}, 32'd0);
    check("t5_frame_count", {16'd0, frameCount}, 32'd0);
    check("t5_idle", {31'd0, idle}, 32'd1);
    check("t5_aborted_bytes", sbQ.size(), 32'd3);
    sbQ.delete();
    @(negedge clk);
    reset = 1'b0;
    pushFrame(4'd0, 32'h0BADF00D);
    nonceValid[0] = 1'b1;
    nonceIn[31:0] = 32'h0BADF00D;
    @(negedge clk);
    nonceValid = '0;
    waitDone("t5_done", 200);
    check("t5_frame_count_end", {16'd0, frameCount}, 32'd1);

    // 6: transmitter never goes busy, each byte advances on the timeout
    doReset();
    txDead = 1'b1;
    pulseCycles.delete();
    pushFrame(4'd1, 32'hCAFEF00D);
    sendNonce(1, 32'hCAFEF00D);
    waitDone("t6_done", 200);
    check("t6_pulse_count", pulseCycles.size(), 32'd5);
    if (pulseCycles.size() >= 5) begin
      for (int i = 1; i < 5; i++)
        check("t6_pulse_spacing", 32'(pulseCycles[i] - pulseCycles[i-1]), 32'd6);
    end
    check("t6_frame_count", {16'd0, frameCount}, 32'd1);
    txDead = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000, expected earlier finish");
    $fatal(1);
  end

endmodule
